// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: lap snapshot layout and recall FSM states.
package stopwatch_pkg;
   localparam int SEC_W   = 6;
   localparam int TENTH_W = 4;

   typedef struct packed {
      logic [SEC_W-1:0]   sec;
      logic [TENTH_W-1:0] tenth;
   } lap_t;

   typedef enum logic [1:0] {
      EMPTY,
      SHOW,
      FETCH
   } recall_state_t;
endpackage

// File: rtl/lap_mem.sv
// Lap storage: one write port, one registered read port.
module lap_mem
   import stopwatch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  lap_t             wdata,
   input  logic [IDX_W-1:0] raddr,
   output lap_t             rdata
);

   lap_t mem [DEPTH];

   // Write-through on address match so a lap written this edge is readable
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (we && (waddr == raddr))
         rdata <= wdata;
      else
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/lap_recall.sv
// Lap buffer and recall controller for the stopwatch display path.
// LAP_OVERWRITE_EN: when defined, a lap captured while full replaces the oldest.
module lap_recall
   import stopwatch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               lap_valid,
   input  logic [SEC_W-1:0]   sec_in,
   input  logic [TENTH_W-1:0] tenth_sec_in,
   input  logic               clear,
   input  logic               recall_next,
   output logic [SEC_W-1:0]   sec_out,
   output logic [TENTH_W-1:0] tenth_sec_out,
   output logic [IDX_W-1:0]   lap_idx,
   output logic [IDX_W:0]     lap_count,
   output logic               out_valid,
   output logic               empty,
   output logic               full
`ifdef LAP_OVERWRITE_EN
`else
 , output logic               overflow
`endif
);

   localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
   localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

   recall_state_t    state;
   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] wr_ptr;
   logic [IDX_W-1:0] rd_off;

   logic [IDX_W-1:0] head_nxt;
   logic [IDX_W-1:0] wr_nxt;
   logic [IDX_W-1:0] rd_off_nxt;
   logic [IDX_W:0]   cnt_nxt;
   logic [IDX_W:0]   rd_off_inc;
   logic [IDX_W-1:0] rd_addr;

   logic accept;
   logic ovw;
   logic mem_we;
   lap_t wr_lap;
   lap_t rd_lap;

   assign empty  = (lap_count == '0);
   assign full   = (lap_count == FULL_CNT);
   assign accept = lap_valid && !full;

`ifdef LAP_OVERWRITE_EN
   assign ovw = lap_valid && full;
`else
   logic drop;
   assign ovw  = 1'b0;
   assign drop = lap_valid && full;
`endif

   assign mem_we       = !rst && !clear && (accept || ovw);
   assign wr_lap.sec   = sec_in;
   assign wr_lap.tenth = tenth_sec_in;
   assign rd_off_inc   = {1'b0, rd_off} + CNT_ONE;

   always_comb begin
      head_nxt   = head;
      wr_nxt     = wr_ptr;
      cnt_nxt    = lap_count;
      rd_off_nxt = rd_off;
      if (clear) begin
         head_nxt   = '0;
         wr_nxt     = '0;
         cnt_nxt    = '0;
         rd_off_nxt = '0;
      end else begin
         if (accept) begin
            wr_nxt  = wr_ptr + PTR_ONE;
            cnt_nxt = lap_count + CNT_ONE;
         end
         if (ovw) begin
            wr_nxt   = wr_ptr + PTR_ONE;
            head_nxt = head + PTR_ONE;
         end
         if ((state == EMPTY) && lap_valid)
            rd_off_nxt = '0;
         // Wrap test uses the count before any same-cycle write
         if ((state == SHOW) && recall_next)
            rd_off_nxt = (rd_off_inc == lap_count) ? '0 : rd_off_inc[IDX_W-1:0];
      end
   end

   // Address from next-cycle pointers so the read lands during FETCH
   assign rd_addr = head_nxt + rd_off_nxt;

   lap_mem #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (wr_lap),
      .raddr (rd_addr),
      .rdata (rd_lap)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= EMPTY;
         head          <= '0;
         wr_ptr        <= '0;
         lap_count     <= '0;
         rd_off        <= '0;
         sec_out       <= '0;
         tenth_sec_out <= '0;
         lap_idx       <= '0;
         out_valid     <= 1'b0;
`ifndef LAP_OVERWRITE_EN
         overflow      <= 1'b0;
`endif
      end else begin
         head      <= head_nxt;
         wr_ptr    <= wr_nxt;
         lap_count <= cnt_nxt;
         rd_off    <= rd_off_nxt;
         if (clear) begin
            state         <= EMPTY;
            sec_out       <= '0;
            tenth_sec_out <= '0;
            lap_idx       <= '0;
            out_valid     <= 1'b0;
`ifndef LAP_OVERWRITE_EN
            overflow      <= 1'b0;
`endif
         end else begin
`ifndef LAP_OVERWRITE_EN
            if (drop)
               overflow <= 1'b1;
`endif
            unique case (state)
               EMPTY: begin
                  if (lap_valid)
                     state <= FETCH;
               end
               SHOW: begin
                  if (recall_next || ovw)
                     state <= FETCH;
               end
               FETCH: begin
                  sec_out       <= rd_lap.sec;
                  tenth_sec_out <= rd_lap.tenth;
                  lap_idx       <= rd_off;
                  out_valid     <= 1'b1;
                  // An overwrite mid-read shifts head, so read again
                  state         <= ovw ? FETCH : SHOW;
               end
               default: state <= EMPTY;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lap_recall.sv
// Self-checking bench for lap_recall against a queue-based lap model.
module tb_lap_recall;
   import stopwatch_pkg::*;

   localparam int DEPTH = 8;
   localparam int IDX_W = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             lap_valid;
   logic [5:0]       sec_in;
   logic [3:0]       tenth_sec_in;
   logic             clear;
   logic             recall_next;
   logic [5:0]       sec_out;
   logic [3:0]       tenth_sec_out;
   logic [IDX_W-1:0] lap_idx;
   logic [IDX_W:0]   lap_count;
   logic             out_valid;
   logic             empty;
   logic             full;
`ifndef LAP_OVERWRITE_EN
   logic             overflow;
`endif

   always #5 clk = ~clk;

   lap_recall #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .lap_valid     (lap_valid),
      .sec_in        (sec_in),
      .tenth_sec_in  (tenth_sec_in),
      .clear         (clear),
      .recall_next   (recall_next),
      .sec_out       (sec_out),
      .tenth_sec_out (tenth_sec_out),
      .lap_idx       (lap_idx),
      .lap_count     (lap_count),
      .out_valid     (out_valid),
      .empty         (empty),
      .full          (full)
`ifndef LAP_OVERWRITE_EN
    , .overflow      (overflow)
`endif
   );

   int   checks = 0;
   int   errors = 0;
   lap_t q[$];
   int   disp = 0;
   bit   ovf_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input bit lv, input int s, input int t,
                       input bit rn, input bit cl);
      lap_valid    = lv;
      sec_in       = 6'(s);
      tenth_sec_in = 4'(t);
      recall_next  = rn;
      clear        = cl;
      @(posedge clk);
      #1;
      lap_valid   = 1'b0;
      recall_next = 1'b0;
      clear       = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic m_cap(input int s, input int t);
      lap_t e;
      e.sec   = 6'(s);
      e.tenth = 4'(t);
      if (q.size() == 0) begin
         q.push_back(e);
         disp = 0;
      end else if (q.size() < DEPTH) begin
         q.push_back(e);
      end else begin
`ifdef LAP_OVERWRITE_EN
         void'(q.pop_front());
         q.push_back(e);
`else
         ovf_m = 1'b1;
`endif
      end
   endtask

   task automatic m_next();
      if (q.size() > 0)
         disp = (disp + 1) % q.size();
   endtask

   task automatic m_clear();
      q.delete();
      disp  = 0;
      ovf_m = 1'b0;
   endtask

   task automatic cmp_all(input string tag);
      int es, et, ei, ev;
      es = 0; et = 0; ei = 0; ev = 0;
      if (q.size() > 0) begin
         es = int'(q[disp].sec);
         et = int'(q[disp].tenth);
         ei = disp;
         ev = 1;
      end
      chk($sformatf("%s.count", tag), 32'(lap_count), q.size());
      chk($sformatf("%s.empty", tag), 32'(empty), (q.size() == 0) ? 1 : 0);
      chk($sformatf("%s.full", tag), 32'(full), (q.size() == DEPTH) ? 1 : 0);
      chk($sformatf("%s.valid", tag), 32'(out_valid), ev);
      chk($sformatf("%s.sec", tag), 32'(sec_out), es);
      chk($sformatf("%s.tenth", tag), 32'(tenth_sec_out), et);
      chk($sformatf("%s.idx", tag), 32'(lap_idx), ei);
`ifndef LAP_OVERWRITE_EN
      chk($sformatf("%s.ovf", tag), 32'(overflow), 32'(ovf_m));
`endif
   endtask

   task automatic cap(input int s, input int t);
      m_cap(s, t);
      step(1'b1, s, t, 1'b0, 1'b0);
      idle(2);
   endtask

   task automatic rec();
      m_next();
      step(1'b0, 0, 0, 1'b1, 1'b0);
      idle(2);
   endtask

   task automatic clr();
      m_clear();
      step(1'b0, 0, 0, 1'b0, 1'b1);
      idle(1);
   endtask

   initial begin
      int prev;
      int r;
      rst          = 1'b1;
      lap_valid    = 1'b0;
      sec_in       = '0;
      tenth_sec_in = '0;
      clear        = 1'b0;
      recall_next  = 1'b0;
      idle(2);
      rst = 1'b0;
      cmp_all("reset");

      // First lap: count moves at the write edge, data one edge later
      m_cap(15, 8);
      step(1'b1, 15, 8, 1'b0, 1'b0);
      chk("first.cnt_early", 32'(lap_count), 1);
      chk("first.valid_early", 32'(out_valid), 0);
      idle(1);
      cmp_all("first");
      chk("first.sec_const", 32'(sec_out), 15);
      idle(1);
      cap(35, 2);
      cap(59, 8);
      cmp_all("three");

      for (int i = 0; i < 3; i++) begin
         prev = disp;
         m_next();
         step(1'b0, 0, 0, 1'b1, 1'b0);
         chk("rec.hold_idx", 32'(lap_idx), prev);
         idle(1);
         cmp_all("rec");
         idle(1);
      end
      chk("wrap.sec", 32'(sec_out), 15);
      chk("wrap.tenth", 32'(tenth_sec_out), 8);

      // Clear lands during the FETCH cycle of a recall
      step(1'b0, 0, 0, 1'b1, 1'b0);
      m_clear();
      step(1'b0, 0, 0, 1'b0, 1'b1);
      cmp_all("clr_fetch");
      idle(1);
      cmp_all("clr_fetch_after");

      for (int i = 0; i <= DEPTH; i++)
         cap(10 + i, i % 10);
      cmp_all("depth1");
      chk("depth1.full", 32'(full), 1);
      chk("depth1.cnt", 32'(lap_count), DEPTH);
`ifdef LAP_OVERWRITE_EN
      chk("depth1.idx0_sec", 32'(sec_out), 11);
`else
      chk("depth1.idx0_sec", 32'(sec_out), 10);
      chk("depth1.ovf", 32'(overflow), 1);
`endif

      clr();
      cap(1, 1);
      cap(2, 2);
      rec();
      cmp_all("simul_pre");
      m_next();
      m_cap(3, 3);
      step(1'b1, 3, 3, 1'b1, 1'b0);
      chk("simul.cnt", 32'(lap_count), 3);
      idle(2);
      cmp_all("simul");
      chk("simul.idx", 32'(lap_idx), 0);

      clr();
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)
            cap(int'($urandom_range(0, 59)), int'($urandom_range(0, 9)));
         else if (r < 9)
            rec();
         else
            clr();
         cmp_all("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
